// File: rtl/radar_tx_defs_pkg.sv
// Shared definitions for the radar TX sample strober: FSM encodings and default idle sample.
package radar_tx_defs_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StRun,
    StFlush
  } state_e;

  localparam logic [31:0] DefaultIdleValue = 32'd0;

endpackage

// File: rtl/radar_tx_sample_fifo.sv
// Synchronous FIFO with first-word-fall-through head, sync clear and occupancy level.
module radar_tx_sample_fifo #(
  parameter int unsigned AW = 4,
  parameter int unsigned W  = 33
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW:0] DepthLvl = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_wr, do_rd;

  assign full    = (level_q == DepthLvl);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem[rd_ptr_q];
  // A full FIFO refuses writes even when a pop happens in the same cycle.
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;

  // Pointer and level next-state; pointers wrap naturally at AW bits.
  always_comb begin
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    unique case ({do_wr, do_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer/level state with async reset and synchronous flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/radar_tx_sample_strober.sv
// Buffers the gated AXI-Stream sample feed and plays it out on the frontend strobe interface.
module radar_tx_sample_strober
  import radar_tx_defs_pkg::*;
#(
  parameter int unsigned FIFO_AW      = 4,
  parameter int unsigned PRIME_THRESH = 4,
  parameter logic [31:0] IDLE_VALUE   = DefaultIdleValue
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic [31:0]        in_tdata,
  input  logic               in_tlast,
  input  logic               in_tvalid,
  output logic               in_tready,
  input  logic               strobe,
  output logic               run,
  output logic [31:0]        sample,
  output logic               underrun,
  output logic               burst_done,
  output logic [31:0]        burst_samples,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam logic [FIFO_AW:0] PrimeLvl = (FIFO_AW + 1)'(PRIME_THRESH);

  state_e             state_q, state_d;
  logic [31:0]        sample_q, sample_d;
  logic               underrun_q, underrun_d;
  logic               done_q, done_d;
  logic [31:0]        bsamp_q, bsamp_d;
  logic [31:0]        bcnt_q, bcnt_d;
  logic [FIFO_AW:0]   tl_cnt_q, tl_cnt_d;

  logic               push, pop, full, empty;
  logic [32:0]        head;
  logic               head_last;

  assign in_tready = ~full;
  assign push      = in_tvalid & ~full;
  assign head_last = head[32];

  radar_tx_sample_fifo #(
    .AW (FIFO_AW),
    .W  (33)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .wr_en   (push),
    .wr_data ({in_tlast, in_tdata}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // Burst FSM: prime, stream on strobe, flush the remainder of a burst after an underrun.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    sample_d   = sample_q;
    underrun_d = 1'b0;
    done_d     = 1'b0;
    bsamp_d    = bsamp_q;
    bcnt_d     = bcnt_q;
    unique case (state_q)
      StIdle: begin
        sample_d = IDLE_VALUE;
        if (!empty) state_d = StPrime;
      end
      StPrime: begin
        sample_d = IDLE_VALUE;
        // A buffered tlast means the whole (short) burst is present already.
        if (fifo_level >= PrimeLvl || tl_cnt_q != '0) state_d = StRun;
      end
      StRun: begin
        if (strobe) begin
          if (!empty) begin
            pop      = 1'b1;
            sample_d = head[31:0];
            bcnt_d   = bcnt_q + 32'd1;
            if (head_last) begin
              bsamp_d = bcnt_q + 32'd1;
              bcnt_d  = '0;
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end else begin
            underrun_d = 1'b1;
            sample_d   = IDLE_VALUE;
            bcnt_d     = '0;
            state_d    = StFlush;
          end
        end
      end
      StFlush: begin
        sample_d = IDLE_VALUE;
        if (!empty) begin
          pop = 1'b1;
          if (head_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Count of tlast-marked entries currently buffered.
  always_comb begin
    tl_cnt_d = tl_cnt_q;
    unique case ({push & in_tlast, pop & head_last})
      2'b10:   tl_cnt_d = tl_cnt_q + 1'b1;
      2'b01:   tl_cnt_d = tl_cnt_q - 1'b1;
      default: tl_cnt_d = tl_cnt_q;
    endcase
  end

  // Control and output registers; clear overrides every other event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sample_q   <= IDLE_VALUE;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
      bsamp_q    <= '0;
      bcnt_q     <= '0;
      tl_cnt_q   <= '0;
    end else if (clear) begin
      state_q    <= StIdle;
      sample_q   <= IDLE_VALUE;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
      bsamp_q    <= '0;
      bcnt_q     <= '0;
      tl_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
      bsamp_q    <= bsamp_d;
      bcnt_q     <= bcnt_d;
      tl_cnt_q   <= tl_cnt_d;
    end
  end

  assign run           = (state_q == StRun);
  assign sample        = sample_q;
  assign underrun      = underrun_q;
  assign burst_done    = done_q;
  assign burst_samples = bsamp_q;

endmodule

// File: tb/tb_radar_tx_sample_strober.sv
// Scoreboard bench for radar_tx_sample_strober: stimulus pushes expected deliveries,
// a monitor pops and compares whenever a strobe is accepted in RUN.
module tb_radar_tx_sample_strober;

  localparam logic [31:0] IdleVal = 32'd0;

  logic        clk = 1'b0;
  logic        reset_n, clear;
  logic [31:0] in_tdata;
  logic        in_tlast, in_tvalid, in_tready;
  logic        strobe, run, underrun, burst_done;
  logic [31:0] sample, burst_samples;
  logic [4:0]  fifo_level;

  always #5 clk = ~clk;

  radar_tx_sample_strober #(
    .FIFO_AW      (4),
    .PRIME_THRESH (4),
    .IDLE_VALUE   (IdleVal)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (clear),
    .in_tdata      (in_tdata),
    .in_tlast      (in_tlast),
    .in_tvalid     (in_tvalid),
    .in_tready     (in_tready),
    .strobe        (strobe),
    .run           (run),
    .sample        (sample),
    .underrun      (underrun),
    .burst_done    (burst_done),
    .burst_samples (burst_samples),
    .fifo_level    (fifo_level)
  );

  typedef struct {
    bit          und;
    logic [31:0] data;
    bit          last;
    logic [31:0] cnt;
  } ev_t;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic fire;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_s(input logic [31:0] d, input bit last, input logic [31:0] cnt);
    ev_t e;
    e.und = 1'b0; e.data = d; e.last = last; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic expect_u();
    ev_t e;
    e.und = 1'b1; e.data = IdleVal; e.last = 1'b0; e.cnt = '0;
    exp_q.push_back(e);
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic [31:0] d, input logic l);
    int   n = 0;
    logic ok;
    in_tdata = d; in_tlast = l; in_tvalid = 1'b1;
    do begin
      ok = in_tready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: word %0h not accepted, got tready=0 expected 1", d);
    end
    in_tvalid = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic strobe_n(input int n);
    strobe = 1'b1;
    repeat (n) @(posedge clk);
    #1 strobe = 1'b0;
  endtask

  task automatic wait_run(input logic val, input string name);
    int n = 0;
    while (run !== val && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, run, val);
  endtask

  // A strobe accepted in RUN produces exactly one scoreboard event.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) fire <= 1'b0;
    else          fire <= run & strobe & ~clear;
  end

  // Monitor: compare DUT response against the head of the expectation queue.
  always @(negedge clk) begin
    ev_t e;
    if (reset_n) begin
      if (fire) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected: got sample %0h expected no delivery", sample);
        end else begin
          e = exp_q.pop_front();
          if (e.und) begin
            chk("underrun_pulse", {31'd0, underrun}, 32'd1);
            chk("underrun_sample", sample, IdleVal);
            chk("underrun_run", {31'd0, run}, 32'd0);
          end else begin
            chk("sample", sample, e.data);
            chk("burst_done", {31'd0, burst_done}, {31'd0, e.last});
            if (e.last) chk("burst_samples", burst_samples, e.cnt);
          end
        end
      end else if (burst_done || underrun) begin
        total++; bad++;
        $display("FAIL spurious_pulse: got done=%0b underrun=%0b expected 0 0",
                 burst_done, underrun);
      end
    end
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; strobe = 1'b0;
    in_tdata = '0; in_tlast = 1'b0; in_tvalid = 1'b0;
    #3;
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_sample", sample, IdleVal);
    chk("rst_level", {27'd0, fifo_level}, 32'd0);
    chk("rst_bsamp", burst_samples, 32'd0);
    chk("rst_pulses", {30'd0, underrun, burst_done}, 32'd0);
    #9 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_tready", {31'd0, in_tready}, 32'd1);

    // 1: 8-sample burst, RUN after 4 buffered
    for (int i = 1; i <= 8; i++) expect_s(32'h1000_0000 + i, i == 8, 32'd8);
    for (int i = 1; i <= 4; i++) send(32'h1000_0000 + i, 1'b0);
    chk("t1_prime_run", {31'd0, run}, 32'd0);
    chk("t1_prime_level", {27'd0, fifo_level}, 32'd4);
    send(32'h1000_0005, 1'b0);
    chk("t1_run_rise", {31'd0, run}, 32'd1);
    for (int i = 6; i <= 8; i++) send(32'h1000_0000 + i, i == 8);
    strobe_n(8);
    chk("t1_run_fall", {31'd0, run}, 32'd0);
    chk("t1_level", {27'd0, fifo_level}, 32'd0);

    // 2: short burst enters RUN through the buffered tlast
    expect_s(32'h2000_0001, 1'b0, 32'd0);
    expect_s(32'h2000_0002, 1'b1, 32'd2);
    send(32'h2000_0001, 1'b0);
    send(32'h2000_0002, 1'b1);
    wait_run(1'b1, "t2_run");
    chk("t2_level", {27'd0, fifo_level}, 32'd2);
    strobe_n(2);
    wait_run(1'b0, "t2_run_fall");

    // 3: underrun after 5 samples, rest of burst flushed
    for (int i = 1; i <= 5; i++) expect_s(32'h3000_0000 + i, 1'b0, 32'd0);
    expect_u();
    for (int i = 1; i <= 5; i++) send(32'h3000_0000 + i, 1'b0);
    wait_run(1'b1, "t3_run");
    strobe_n(6);
    chk("t3_run_after_ur", {31'd0, run}, 32'd0);
    chk("t3_sample_idle", sample, IdleVal);
    for (int i = 6; i <= 9; i++) send(32'h3000_0000 + i, i == 9);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_flushed", {27'd0, fifo_level}, 32'd0);
    chk("t3_run_idle", {31'd0, run}, 32'd0);
    chk("t3_bsamp_kept", burst_samples, 32'd2);

    // 4: fill to full, then stream 40 samples across the pointer wrap
    for (int i = 1; i <= 40; i++) expect_s(32'h4000_0000 + i, i == 40, 32'd40);
    for (int i = 1; i <= 16; i++) send(32'h4000_0000 + i, 1'b0);
    chk("t4_full_tready", {31'd0, in_tready}, 32'd0);
    chk("t4_full_level", {27'd0, fifo_level}, 32'd16);
    strobe = 1'b1;
    @(posedge clk); #1;
    chk("t4_tready_back", {31'd0, in_tready}, 32'd1);
    chk("t4_level_15", {27'd0, fifo_level}, 32'd15);
    for (int i = 17; i <= 40; i++) send(32'h4000_0000 + i, i == 40);
    wait_run(1'b0, "t4_run_fall");
    strobe = 1'b0;

    // 5: clear during RUN with 6 entries held
    for (int i = 1; i <= 6; i++) send(32'h5000_0000 + i, 1'b0);
    chk("t5_run", {31'd0, run}, 32'd1);
    chk("t5_level", {27'd0, fifo_level}, 32'd6);
    clear = 1'b1; strobe = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; strobe = 1'b0;
    chk("t5_clr_level", {27'd0, fifo_level}, 32'd0);
    chk("t5_clr_run", {31'd0, run}, 32'd0);
    chk("t5_clr_sample", sample, IdleVal);
    chk("t5_clr_done", {31'd0, burst_done}, 32'd0);
    chk("t5_clr_bsamp", burst_samples, 32'd0);

    // 6: async reset mid-burst, then a clean restart
    expect_s(32'h6000_0001, 1'b0, 32'd0);
    expect_s(32'h6000_0002, 1'b0, 32'd0);
    for (int i = 1; i <= 6; i++) send(32'h6000_0000 + i, 1'b0);
    strobe_n(2);
    #6 reset_n = 1'b0;
    #1;
    chk("t6_async_run", {31'd0, run}, 32'd0);
    chk("t6_async_sample", sample, IdleVal);
    chk("t6_async_level", {27'd0, fifo_level}, 32'd0);
    #4 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_tready", {31'd0, in_tready}, 32'd1);
    expect_s(32'h6100_0001, 1'b0, 32'd0);
    expect_s(32'h6100_0002, 1'b1, 32'd2);
    send(32'h6100_0001, 1'b0);
    send(32'h6100_0002, 1'b1);
    wait_run(1'b1, "t6_restart_run");
    strobe_n(2);
    wait_run(1'b0, "t6_restart_fall");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
